// File: rtl/instr_fetch.sv
// instr_fetch: fetch stage between the PC register and decode.
// Optional macro FETCH_MISALIGN_CHECK_EN: misaligned redirects fault and halt.
//
// Ports:
//   clk, reset            clock, async active-high reset
//   current_pc            PC register output
//   pc_en, next_pc        PC register write enable and write value
//   imem_req_valid/ready  fetch request handshake, address imem_req_addr
//   imem_resp_valid/data  in-order instruction responses
//   redirect_valid/target single-cycle redirect from execute
//   if_valid/ready        output handshake toward decode
//   if_pc, if_instr       PC and word of the output instruction
//   fetch_fault           sticky misaligned-redirect flag
module instr_fetch #(
  parameter int DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] current_pc,
  output logic        pc_en,
  output logic [31:0] next_pc,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  output logic        if_valid,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  input  logic        if_ready,
  output logic        fetch_fault
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [CW-1:0] FULL = CW'(DEPTH);
  localparam logic [CW:0] LIMIT = (CW+1)'(DEPTH);
  localparam logic [CW-1:0] ONE_C = CW'(1);
  localparam logic [AW-1:0] ONE_A = AW'(1);

  typedef enum logic [1:0] {
    IDLE,
    FETCH,
    HALT
  } state_t;

  state_t state;

  logic [CW-1:0] inflight;
  logic [CW-1:0] discard;
  logic [CW-1:0] fcnt;
  logic [AW-1:0] sq_rd;
  logic [AW-1:0] sq_wr;
  logic [AW-1:0] fq_rd;
  logic [AW-1:0] fq_wr;
  logic [31:0]   sq_pc  [DEPTH];
  logic [31:0]   fq_pc  [DEPTH];
  logic [31:0]   fq_ins [DEPTH];

  logic          fetching;
  logic          redir;
  logic          misal;
  logic          pop;
  logic          push;
  logic          drop;
  logic          credit;
  logic          accept;
  logic [CW-1:0] fcnt_eff;

  assign fetching = state == FETCH;
  assign redir    = fetching & redirect_valid;

`ifdef FETCH_MISALIGN_CHECK_EN
  logic fault;
  assign misal       = redir & (redirect_target[1:0] != 2'b00);
  assign fetch_fault = fault;
`else
  logic unused_tgt;
  assign unused_tgt  = ^redirect_target[1:0];
  assign misal       = 1'b0;
  assign fetch_fault = 1'b0;
`endif

  assign if_valid = fcnt != '0;
  assign if_pc    = fq_pc[fq_rd];
  assign if_instr = fq_ins[fq_rd];
  assign pop      = if_valid & if_ready;

  // A pop only frees credit this cycle when the FIFO is not full;
  // a full FIFO's freed slot shows up through fcnt next cycle.
  assign fcnt_eff = fcnt - CW'(pop & (fcnt != FULL));
  assign credit   = ({1'b0, inflight} + {1'b0, fcnt_eff}) < LIMIT;

  assign imem_req_valid = fetching & credit & ~redirect_valid;
  assign imem_req_addr  = current_pc;
  assign accept         = imem_req_valid & imem_req_ready;

  assign pc_en   = accept | (redir & ~misal);
  assign next_pc = redir ? {redirect_target[31:2], 2'b00}
                         : current_pc + 32'd4;

  // Responses are dropped while stale, on a redirect, or outside FETCH.
  assign drop = redir | (discard != '0) | ~fetching;
  assign push = imem_resp_valid & ~drop;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      inflight <= '0;
      discard  <= '0;
      fcnt     <= '0;
      sq_rd    <= '0;
      sq_wr    <= '0;
      fq_rd    <= '0;
      fq_wr    <= '0;
`ifdef FETCH_MISALIGN_CHECK_EN
      fault    <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE:  state <= FETCH;
        FETCH: if (misal) state <= HALT;
        HALT:  state <= HALT;
        default: state <= IDLE;
      endcase
`ifdef FETCH_MISALIGN_CHECK_EN
      if (misal) fault <= 1'b1;
`endif
      inflight <= inflight + CW'(accept) - CW'(imem_resp_valid);
      if (redir)
        discard <= inflight - CW'(imem_resp_valid);
      else if (imem_resp_valid && discard != '0)
        discard <= discard - ONE_C;
      if (accept)          sq_wr <= sq_wr + ONE_A;
      if (imem_resp_valid) sq_rd <= sq_rd + ONE_A;
      if (redir) begin
        fq_rd <= '0;
        fq_wr <= '0;
        fcnt  <= '0;
      end else begin
        if (push) fq_wr <= fq_wr + ONE_A;
        if (pop)  fq_rd <= fq_rd + ONE_A;
        fcnt <= fcnt + CW'(push) - CW'(pop);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) sq_pc[sq_wr] <= current_pc;
    if (push) begin
      fq_pc[fq_wr]  <= sq_pc[sq_rd];
      fq_ins[fq_wr] <= imem_resp_data;
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
// tb_instr_fetch: randomized scoreboard bench for instr_fetch.
// Reference: in-order PC stream model, flushed on redirect.
module tb_instr_fetch;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] current_pc;
  logic        pc_en;
  logic [31:0] next_pc;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready = 1'b0;
  logic        imem_resp_valid = 1'b0;
  logic [31:0] imem_resp_data = '0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_target = '0;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_instr;
  logic        if_ready = 1'b0;
  logic        fetch_fault;

  always #5 clk = ~clk;

  instr_fetch #(.DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset(reset),
    .current_pc(current_pc),
    .pc_en(pc_en),
    .next_pc(next_pc),
    .imem_req_valid(imem_req_valid),
    .imem_req_addr(imem_req_addr),
    .imem_req_ready(imem_req_ready),
    .imem_resp_valid(imem_resp_valid),
    .imem_resp_data(imem_resp_data),
    .redirect_valid(redirect_valid),
    .redirect_target(redirect_target),
    .if_valid(if_valid),
    .if_pc(if_pc),
    .if_instr(if_instr),
    .if_ready(if_ready),
    .fetch_fault(fetch_fault)
  );

  // PC register owned by the environment
  always @(posedge clk or posedge reset)
    if (reset) current_pc <= 32'h0100_0000;
    else if (pc_en) current_pc <= next_pc;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] ins;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend_addr[$];
  int          pend_due[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int accepts = 0;
  int rdy_mode = 1;
  int ifr_mode = 1;
  int lat_min = 1;
  int lat_max = 1;
  bit resp_rand = 0;
  bit redir_req = 0;
  logic [31:0] redir_tgt = '0;
  logic [31:0] model_pc = 32'h0100_0000;
  bit halted = 0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  // Memory / environment driver: inputs change 1 time unit after posedge
  always begin
    @(posedge clk);
    #1;
    cyc++;
    imem_req_ready = (rdy_mode == 1) ? 1'b1 :
                     (rdy_mode == 2) ? 1'b0 : ($urandom % 3 != 0);
    if_ready = (ifr_mode == 1) ? 1'b1 :
               (ifr_mode == 2) ? 1'b0 : ($urandom % 3 != 0);
    if (pend_addr.size() > 0 && pend_due[0] <= cyc &&
        (!resp_rand || ($urandom % 4 != 0))) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(pend_addr[0]);
    end else begin
      imem_resp_valid = 1'b0;
      imem_resp_data  = '0;
    end
    redirect_valid  = redir_req;
    redirect_target = redir_tgt;
    redir_req = 0;
  end

  // Stimulus bookkeeping: expected stream built from observed handshakes
  always begin
    @(negedge clk);
    #1;
    if (!reset) begin
      if (imem_resp_valid && pend_addr.size() > 0) begin
        void'(pend_addr.pop_front());
        void'(pend_due.pop_front());
      end
      if (halted) chk("halt_req_valid", {31'b0, imem_req_valid}, 32'd0);
      if (redirect_valid && !halted) begin
        chk("redir_no_req", {31'b0, imem_req_valid}, 32'd0);
        exp_q.delete();
        model_pc = {redirect_target[31:2], 2'b00};
`ifdef FETCH_MISALIGN_CHECK_EN
        if (redirect_target[1:0] != 2'b00) halted = 1;
`endif
      end
      if (imem_req_valid && imem_req_ready) begin
        accepts++;
        chk("req_addr", imem_req_addr, model_pc);
        exp_q.push_back('{pc: model_pc, ins: mem_word(model_pc)});
        pend_addr.push_back(imem_req_addr);
        pend_due.push_back(cyc + $urandom_range(lat_max, lat_min));
        model_pc = model_pc + 32'd4;
      end
    end
  end

  // Monitor: compares every delivered instruction with the scoreboard
  always @(negedge clk) begin
    if (!reset && if_valid && if_ready) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL out_unexpected got pc=%h exp=none", if_pc);
      end else begin
        chk("out_pc", if_pc, exp_q[0].pc);
        chk("out_instr", if_instr, exp_q[0].ins);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic do_redirect(input logic [31:0] tgt);
    @(negedge clk);
    #2;
    redir_req = 1;
    redir_tgt = tgt;
    @(negedge clk);
  endtask

  task automatic set_modes(input int r, input int f, input int lo,
                           input int hi, input bit rr);
    @(negedge clk);
    #2;
    rdy_mode = r;
    ifr_mode = f;
    lat_min = lo;
    lat_max = hi;
    resp_rand = rr;
  endtask

  initial begin
    int n;
    int a0;
    logic [31:0] a;

    // reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_pc_en", {31'b0, pc_en}, 32'd0);
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_if_valid", {31'b0, if_valid}, 32'd0);
    chk("rst_fault", {31'b0, fetch_fault}, 32'd0);
    chk("rst_next_pc", next_pc, 32'h0100_0004);
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("idle_no_req", {31'b0, imem_req_valid}, 32'd0);
    @(negedge clk);
    chk("first_req", {31'b0, imem_req_valid}, 32'd1);
    chk("first_addr", imem_req_addr, 32'h0100_0000);

    // throughput: one instruction per cycle
    n = 0;
    do begin @(negedge clk); n++; end while (!if_valid && n < 20);
    chk("tp_valid0", {31'b0, if_valid}, 32'd1);
    chk("tp_pc0", if_pc, 32'h0100_0000);
    chk("tp_ins0", if_instr, mem_word(32'h0100_0000));
    @(negedge clk);
    chk("tp_valid1", {31'b0, if_valid}, 32'd1);
    chk("tp_pc1", if_pc, 32'h0100_0004);
    @(negedge clk);
    chk("tp_valid2", {31'b0, if_valid}, 32'd1);
    chk("tp_pc2", if_pc, 32'h0100_0008);

    // decode stalled: credit limits accepted fetches
    set_modes(1, 2, 1, 1, 0);
    a0 = accepts;
    repeat (10) @(negedge clk);
    #2;
    chk("stall_accepts", {31'b0, (accepts - a0) <= DEPTH}, 32'd1);
    chk("stall_no_req", {31'b0, imem_req_valid}, 32'd0);
    set_modes(1, 1, 5, 5, 0);

    // redirect with two requests in flight
    n = 0;
    while (pend_addr.size() != 2 && n < 40) begin
      @(negedge clk); #2; n++;
    end
    chk("two_inflight", pend_addr.size(), 32'd2);
    do_redirect(32'h0100_0100);
    chk("redir_pc_en", {31'b0, pc_en}, 32'd1);
    chk("redir_next_pc", next_pc, 32'h0100_0100);
    n = 0;
    do begin @(negedge clk); n++; end while (!if_valid && n < 40);
    chk("redir_out_pc", if_pc, 32'h0100_0100);

    // memory not ready: PC holds
    set_modes(2, 1, 1, 1, 0);
    @(negedge clk);
    a = imem_req_addr;
    chk("nrdy_pc_en0", {31'b0, pc_en}, 32'd0);
    @(negedge clk);
    chk("nrdy_pc_en1", {31'b0, pc_en}, 32'd0);
    chk("nrdy_addr1", imem_req_addr, a);
    @(negedge clk);
    chk("nrdy_pc_en2", {31'b0, pc_en}, 32'd0);
    chk("nrdy_addr2", imem_req_addr, a);
    set_modes(1, 1, 1, 1, 0);

    // PC wrap
    do_redirect(32'hFFFF_FFFC);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(imem_req_valid && imem_req_ready) && n < 30);
    chk("wrap_addr", imem_req_addr, 32'hFFFF_FFFC);
    chk("wrap_next_pc", next_pc, 32'h0000_0000);
    chk("wrap_pc_en", {31'b0, pc_en}, 32'd1);
    do_redirect(32'h0100_0000);

    // randomized traffic
    set_modes(0, 0, 1, 3, 1);
    for (int i = 0; i < 1500; i++) begin
      @(negedge clk);
      #2;
      if ($urandom % 40 == 0) begin
        redir_req = 1;
        redir_tgt = 32'h0100_0000 + (($urandom % 256) << 2);
      end
    end

    // misaligned redirect
    set_modes(1, 1, 1, 1, 0);
    repeat (3) @(negedge clk);
    do_redirect(32'h0100_0102);
`ifdef FETCH_MISALIGN_CHECK_EN
    chk("mis_pc_en", {31'b0, pc_en}, 32'd0);
    @(negedge clk);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd1);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("mis_req_valid", {31'b0, imem_req_valid}, 32'd0);
      chk("mis_if_valid", {31'b0, if_valid}, 32'd0);
    end
`else
    chk("mis_pc_en", {31'b0, pc_en}, 32'd1);
    chk("mis_next_pc", next_pc, 32'h0100_0100);
    n = 0;
    do begin @(negedge clk); n++; end
    while (!(imem_req_valid && imem_req_ready) && n < 30);
    chk("mis_fetch_addr", imem_req_addr, 32'h0100_0100);
    chk("mis_fault", {31'b0, fetch_fault}, 32'd0);
`endif

    // drain: everything accepted is delivered
    set_modes(2, 1, 1, 1, 0);
    n = 0;
    while ((exp_q.size() != 0 || pend_addr.size() != 0) && n < 200) begin
      @(negedge clk); #2; n++;
    end
    chk("drain_exp_empty", exp_q.size(), 32'd0);
    chk("drain_pend_empty", pend_addr.size(), 32'd0);
    @(negedge clk);
    chk("drain_if_valid", {31'b0, if_valid}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
